sa_main: RTL

SA_MAIN -- requirements
Module: sa_main

---
 rtl/sa_main_pkg.sv | 48 ++++
 rtl/sa_main_rr_arb_5.sv | 33 +++
 rtl/sa_main.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sa_main_pkg.sv
// -----------------------------------------------------------------------------
// sa_main_pkg -- shared defines and types for the switch allocator.
//
// Holds the global macros `N (port count, fixed at 5), `DW (flit data width,
// used by the surrounding router), and the per-output FSM state encodings
// `SA_FREE / `SA_LOCKED, plus small helpers shared by sa_main and rr_arb_5.
//
// Configuration macro: SA_LOCK_EN (wormhole locking) is consumed by sa_main.
// -----------------------------------------------------------------------------
`ifndef SA_MAIN_DEFS
`define SA_MAIN_DEFS
`define N         5
`define DW        32
`define SA_FREE   1'b0
`define SA_LOCKED 1'b1
`endif

package sa_main_pkg;

    localparam int NP = `N;   // port count; the arbiter is hard-wired for 5
    localparam int PW = 3;    // pointer / index width for 5 ports

    typedef enum logic {
        ST_FREE   = `SA_FREE,
        ST_LOCKED = `SA_LOCKED
    } sa_state_e;

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [NP-1:0] v);
        return (v != '0) && ((v & (v - {{(NP-1){1'b0}}, 1'b1})) == '0);
    endfunction

    // Index of the set bit of a one-hot (or zero) vector.
    function automatic logic [PW-1:0] oh_to_idx(input logic [NP-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            if (v[i]) r = PW'(i);
        end
        return r;
    endfunction

    // Round-robin successor, 4 wraps to 0.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
        return (idx == PW'(NP - 1)) ? '0 : idx + PW'(1);
    endfunction

endpackage

// File: rtl/sa_main_rr_arb_5.sv
// -----------------------------------------------------------------------------
// rr_arb_5 -- combinational 5-way round-robin arbiter.
//
// Ports:
//   i_req  [4:0] : request vector (already masked for eligibility)
//   i_ptr  [2:0] : highest-priority index (0..4)
//   o_gnt  [4:0] : one-hot grant to the first requester at or after i_ptr,
//                  wrapping 4->0; zero when nothing requests
// -----------------------------------------------------------------------------
module rr_arb_5
    import sa_main_pkg::*;
(
    input  logic [NP-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NP-1:0] o_gnt
);

    always_comb begin
        logic v_found;
        int   v_idx;
        o_gnt   = '0;
        v_found = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < NP; k++) begin
            v_idx = (int'(i_ptr) + k) % NP;
            if (!v_found && i_req[v_idx]) begin
                o_gnt[v_idx] = 1'b1;
                v_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_main.sv
// -----------------------------------------------------------------------------
// sa_main -- 5x5 switch allocator with one round-robin arbiter per output.
//
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   req_from_P0..P4   [4:0]    : one-hot output request per input (0 = idle)
//   tail_from_P0..P4           : requesting flit is a tail / single flit
//   ready_of_OP       [4:0]    : downstream credit available per output
//   sel_for_OP0..OP4  [4:0]    : registered one-hot crossbar input select
//   grant_to_P        [4:0]    : OR of all selects, one bit per input
//   o_dbg_state       [4:0]    : per-output FSM state (1 = locked)
//   o_dbg_owner  [4:0][2:0]    : per-output lock owner
//   o_dbg_ptr    [4:0][2:0]    : per-output round-robin pointer
//
// Handshake: an input holds its request (and tail) stable until it sees its
// grant_to_P bit in the cycle after sampling; a grant is only issued when the
// output's ready bit was high at the sampling edge, so a grant always means
// the flit traverses in that cycle.
//
// Config: define SA_LOCK_EN for wormhole locking (output stays with one input
// from head to tail). Without it each flit is arbitrated independently.
// -----------------------------------------------------------------------------
module sa_main
    import sa_main_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [`N-1:0]         req_from_P0,
    input  logic [`N-1:0]         req_from_P1,
    input  logic [`N-1:0]         req_from_P2,
    input  logic [`N-1:0]         req_from_P3,
    input  logic [`N-1:0]         req_from_P4,
    input  logic                  tail_from_P0,
    input  logic                  tail_from_P1,
    input  logic                  tail_from_P2,
    input  logic                  tail_from_P3,
    input  logic                  tail_from_P4,
    input  logic [`N-1:0]         ready_of_OP,
    output logic [`N-1:0]         sel_for_OP0,
    output logic [`N-1:0]         sel_for_OP1,
    output logic [`N-1:0]         sel_for_OP2,
    output logic [`N-1:0]         sel_for_OP3,
    output logic [`N-1:0]         sel_for_OP4,
    output logic [`N-1:0]         grant_to_P,
    output logic [NP-1:0]         o_dbg_state,
    output logic [NP-1:0][PW-1:0] o_dbg_owner,
    output logic [NP-1:0][PW-1:0] o_dbg_ptr
);

    logic [NP-1:0][NP-1:0] w_req;       // [input][output]
    logic [NP-1:0]         w_req_ok;
    logic [NP-1:0]         w_tail;
    logic [NP-1:0][NP-1:0] w_mask;      // [output][input] eligibility from FSM
    logic [NP-1:0][NP-1:0] w_elig;      // [output][input]
    logic [NP-1:0][NP-1:0] w_arb_gnt;
    logic [NP-1:0][NP-1:0] w_gnt;
    logic [NP-1:0]         w_gnt_any;
    logic [NP-1:0][PW-1:0] w_gnt_idx;
    logic [NP-1:0][PW-1:0] w_ptr_nxt;

    logic                  r_armed;     // blocks sampling on the first edge after reset
    logic [NP-1:0][NP-1:0] r_sel;
    logic [NP-1:0][PW-1:0] r_ptr;

    assign w_req  = {req_from_P4, req_from_P3, req_from_P2, req_from_P1, req_from_P0};
    assign w_tail = {tail_from_P4, tail_from_P3, tail_from_P2, tail_from_P1, tail_from_P0};

    // Malformed (multi-hot) requests are dropped as if idle.
    always_comb begin
        w_req_ok = '0;
        for (int i = 0; i < NP; i++) w_req_ok[i] = is_onehot(w_req[i]);
    end

    always_comb begin
        w_elig = '0;
        for (int j = 0; j < NP; j++) begin
            for (int i = 0; i < NP; i++) begin
                w_elig[j][i] = r_armed & w_req_ok[i] & w_req[i][j] & w_mask[j][i];
            end
        end
    end

    for (genvar j = 0; j < NP; j++) begin : g_arb
        rr_arb_5 u_arb (
            .i_req (w_elig[j]),
            .i_ptr (r_ptr[j]),
            .o_gnt (w_arb_gnt[j])
        );
    end

    // Without a credit the output neither grants nor changes state.
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = '0;
        w_gnt_idx = '0;
        for (int j = 0; j < NP; j++) begin
            w_gnt[j]     = ready_of_OP[j] ? w_arb_gnt[j] : '0;
            w_gnt_any[j] = |w_gnt[j];
            w_gnt_idx[j] = oh_to_idx(w_gnt[j]);
        end
    end

`ifdef SA_LOCK_EN
    sa_state_e             r_state [NP];
    sa_state_e             w_state_nxt [NP];
    logic [NP-1:0][PW-1:0] r_owner;
    logic [NP-1:0][PW-1:0] w_owner_nxt;
    logic [NP-1:0]         w_gnt_tail;

    always_comb begin
        w_gnt_tail = '0;
        for (int j = 0; j < NP; j++) w_gnt_tail[j] = |(w_gnt[j] & w_tail);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < NP; j++) r_state[j] <= ST_FREE;
            r_owner <= '0;
        end else begin
            for (int j = 0; j < NP; j++) r_state[j] <= w_state_nxt[j];
            r_owner <= w_owner_nxt;
        end
    end

    // FSM next state: a head/body grant on a free output locks it to that
    // input; the tail grant of the owner frees it. A tail on a free output is
    // a single-flit packet and leaves it free.
    always_comb begin
        for (int j = 0; j < NP; j++) w_state_nxt[j] = r_state[j];
        w_owner_nxt = r_owner;
        for (int j = 0; j < NP; j++) begin
            if (w_gnt_any[j]) begin
                if (r_state[j] == ST_FREE && !w_gnt_tail[j]) begin
                    w_state_nxt[j] = ST_LOCKED;
                    w_owner_nxt[j] = w_gnt_idx[j];
                end else if (r_state[j] == ST_LOCKED && w_gnt_tail[j]) begin
                    w_state_nxt[j] = ST_FREE;
                end
            end
        end
    end

    // FSM outputs: eligibility mask and debug view.
    always_comb begin
        w_mask      = '1;
        o_dbg_state = '0;
        o_dbg_owner = r_owner;
        for (int j = 0; j < NP; j++) begin
            o_dbg_state[j] = r_state[j];
            if (r_state[j] == ST_LOCKED) w_mask[j] = {{(NP-1){1'b0}}, 1'b1} << r_owner[j];
        end
    end

    // Pointer only moves once the packet is complete.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int j = 0; j < NP; j++) begin
            if (w_gnt_any[j] && w_gnt_tail[j]) w_ptr_nxt[j] = ptr_next(w_gnt_idx[j]);
        end
    end
`else
    logic w_unused_tail;
    assign w_unused_tail = ^w_tail;

    assign w_mask      = '1;
    assign o_dbg_state = '0;
    assign o_dbg_owner = '0;

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int j = 0; j < NP; j++) begin
            if (w_gnt_any[j]) w_ptr_nxt[j] = ptr_next(w_gnt_idx[j]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_armed <= 1'b0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_armed <= 1'b1;
            r_sel   <= w_gnt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign sel_for_OP0 = r_sel[0];
    assign sel_for_OP1 = r_sel[1];
    assign sel_for_OP2 = r_sel[2];
    assign sel_for_OP3 = r_sel[3];
    assign sel_for_OP4 = r_sel[4];
    assign o_dbg_ptr   = r_ptr;

    always_comb begin
        grant_to_P = '0;
        for (int j = 0; j < NP; j++) grant_to_P = grant_to_P | r_sel[j];
    end

endmodule
